// File: rtl/wac_epp_reader_if.sv
// wac_epp_reader_if: bundles the capture-controller, EPP host and BRAM signals
// of the EPP sample read-back block.
//   master : driven by the environment (start, nSamples, EPP inputs, BRAM data)
//   slave  : the reader (BRAM address, EPP byte/wait, busy/done status)
interface wac_epp_reader_if;
  logic        start;
  logic [11:0] nSamples;
  logic        dataStb;
  logic        eppWrite;
  logic [1:0]  addrEpp;
  logic [11:0] busBramAddr;
  logic [11:0] busBramIn;
  logic [7:0]  eppDataOut;
  logic        eppWait;
  logic        busy;
  logic        done;

  modport master (
    output start, nSamples, dataStb, eppWrite, addrEpp, busBramIn,
    input  busBramAddr, eppDataOut, eppWait, busy, done
  );

  modport slave (
    input  start, nSamples, dataStb, eppWrite, addrEpp, busBramIn,
    output busBramAddr, eppDataOut, eppWait, busy, done
  );
endinterface

// File: rtl/wac_epp_reader.sv
// wac_epp_reader: streams nSamples 12-bit BRAM samples to an EPP host as two
// bytes each (low byte, then {4'h0, high nibble}), handshaking every byte with
// eppWait.
//   clk  : system clock, rising edge
//   rstN : asynchronous active-low reset
//   bus  : slave modport of wac_epp_reader_if (start/nSamples, EPP strobe,
//          direction and address, BRAM address/data, eppDataOut/eppWait,
//          busy/done)
//
// state   | meaning
// IDLE    | waiting for start; host strobes answered with 8'h00
// FETCH   | BRAM latency cycle, sample captured at its end
// READY   | sample held, waiting for a qualified host strobe
// HOLD    | byte presented, eppWait high until the strobe releases
// RELEASE | advance byte pointer / sample address, or finish
module wac_epp_reader #(
  parameter int       SYNC_STAGES = 2,
  parameter bit [1:0] DATA_ADDR   = 2'd3
) (
  input logic              clk,
  input logic              rstN,
  wac_epp_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_READY, S_HOLD, S_RELEASE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_stb_sync;
  logic [SYNC_STAGES-1:0] r_wr_sync;
  logic                   r_stb_prev;
  logic [11:0]            r_count;
  logic [11:0]            r_addr;
  logic [11:0]            r_sample;
  logic                   r_byte_sel;
  logic [7:0]             r_data;
  logic                   r_wait;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pending;
  logic                   r_idle_hs;

  logic w_stb_s;
  logic w_wr_s;
  logic w_qual;
  logic w_last;

  assign w_stb_s = r_stb_sync[SYNC_STAGES-1];
  assign w_wr_s  = r_wr_sync[SYNC_STAGES-1];
  // addrEpp is stable while the raw strobe is low, so by the time the
  // synchronised fall is seen it can be sampled directly.
  assign w_qual  = r_stb_prev & ~w_stb_s & w_wr_s & (bus.addrEpp == DATA_ADDR);
  assign w_last  = (r_addr == r_count - 12'd1);

  assign bus.busBramAddr = r_addr;
  assign bus.eppDataOut  = r_data;
  assign bus.eppWait     = r_wait;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_stb_sync <= '1;
      r_wr_sync  <= '1;
      r_stb_prev <= 1'b1;
    end else begin
      r_stb_sync[0] <= bus.dataStb;
      r_wr_sync[0]  <= bus.eppWrite;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stb_sync[i] <= r_stb_sync[i-1];
        r_wr_sync[i]  <= r_wr_sync[i-1];
      end
      r_stb_prev <= w_stb_s;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= S_IDLE;
      r_count    <= 12'd0;
      r_addr     <= 12'd0;
      r_sample   <= 12'd0;
      r_byte_sel <= 1'b0;
      r_data     <= 8'h00;
      r_wait     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pending  <= 1'b0;
      r_idle_hs  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // A dummy handshake started in IDLE is released wherever the FSM has
      // gone since, so a start arriving mid-handshake cannot hang the host.
      if (r_idle_hs && w_stb_s) begin
        r_wait    <= 1'b0;
        r_idle_hs <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_qual) begin
            r_data    <= 8'h00;
            r_wait    <= 1'b1;
            r_idle_hs <= 1'b1;
          end
          if (bus.start) begin
            if (bus.nSamples != 12'd0) begin
              r_count    <= bus.nSamples;
              r_addr     <= 12'd0;
              r_byte_sel <= 1'b0;
              r_busy     <= 1'b1;
              r_pending  <= 1'b0;
              r_state    <= S_FETCH;
            end else begin
              r_done <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          r_sample <= bus.busBramIn;
          if (w_qual) r_pending <= 1'b1;
          r_state <= S_READY;
        end

        S_READY: begin
          if (w_qual || r_pending) begin
            r_pending <= 1'b0;
            r_data    <= r_byte_sel ? {4'h0, r_sample[11:8]} : r_sample[7:0];
            r_wait    <= 1'b1;
            r_state   <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (w_stb_s) begin
            r_wait  <= 1'b0;
            r_state <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          if (!r_byte_sel) begin
            r_byte_sel <= 1'b1;
            r_state    <= S_READY;
          end else if (!w_last) begin
            r_addr     <= r_addr + 12'd1;
            r_byte_sel <= 1'b0;
            r_state    <= S_FETCH;
          end else begin
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_addr     <= 12'd0;
            r_byte_sel <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wac_epp_reader.sv
module tb_wac_epp_reader;
  localparam int       SYNC = 2;
  localparam bit [1:0] DADDR = 2'd3;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  wac_epp_reader_if bus ();
  wac_epp_reader #(.SYNC_STAGES(SYNC), .DATA_ADDR(DADDR)) dut (
    .clk(clk), .rstN(rstN), .bus(bus)
  );

  logic [11:0] mem [0:15];
  assign bus.busBramIn = mem[bus.busBramAddr[3:0]];

  int total = 0;
  int bad = 0;
  logic [7:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sample(input logic [11:0] s);
    sb_q.push_back(s[7:0]);
    sb_q.push_back({4'h0, s[11:8]});
  endtask

  task automatic pulse_start(input logic [11:0] n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.nSamples = n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Host read of one byte: waits for eppWait, checks the byte against the
  // scoreboard, then releases the strobe and waits for eppWait to drop.
  task automatic host_read(input bit timed);
    int n;
    logic [7:0] exp;
    logic [7:0] held;
    bit moved;
    @(negedge clk);
    bus.addrEpp = DADDR;
    bus.eppWrite = 1'b1;
    bus.dataStb = 1'b0;
    n = 0;
    while (bus.eppWait !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("wait_rise", bus.eppWait, 1'b1);
    if (timed) chk("wait_rise_latency", n, SYNC + 1);
    if (sb_q.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      exp = sb_q.pop_front();
      chk("byte", bus.eppDataOut, exp);
    end
    held = bus.eppDataOut;
    moved = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.eppDataOut !== held) moved = 1'b1; end
    bus.dataStb = 1'b1;
    n = 0;
    while (bus.eppWait !== 1'b0 && n < 20) begin
      @(posedge clk); #1; n++;
      if (bus.eppDataOut !== held) moved = 1'b1;
    end
    chk("wait_fall", bus.eppWait, 1'b0);
    if (timed) begin
      chk("wait_fall_latency", n, SYNC + 1);
      chk("data_stable", moved, 1'b0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic host_ignored(input logic [1:0] a, input logic wr);
    bit seen;
    @(negedge clk);
    bus.addrEpp = a;
    bus.eppWrite = wr;
    bus.dataStb = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (bus.eppWait) seen = 1'b1; end
    @(negedge clk);
    bus.dataStb = 1'b1;
    bus.eppWrite = 1'b1;
    repeat (5) begin @(posedge clk); #1; if (bus.eppWait) seen = 1'b1; end
    chk("ignored_strobe", seen, 1'b0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("done_pulse", bus.done, 1'b1);
    chk("busy_at_done", bus.busy, 1'b0);
    @(posedge clk); #1;
    chk("done_single", bus.done, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, bus.busBramAddr, 12'd0);
    chk({tag, "_data"}, bus.eppDataOut, 8'h00);
    chk({tag, "_wait"}, bus.eppWait, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
  endtask

  initial begin
    bit busy_seen;
    bus.start = 1'b0;
    bus.nSamples = 12'd0;
    bus.dataStb = 1'b1;
    bus.eppWrite = 1'b1;
    bus.addrEpp = 2'd0;
    for (int i = 0; i < 16; i++) mem[i] = 12'd0;

    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    // Basic two-sample read-back with timing checked on the first byte.
    mem[0] = 12'h144;
    mem[1] = 12'h147;
    pulse_start(12'd2);
    chk("busy_after_start", bus.busy, 1'b1);
    push_sample(mem[0]);
    push_sample(mem[1]);
    host_read(1'b1);
    host_read(1'b0);
    host_read(1'b1);
    host_read(1'b0);
    wait_done();

    // Unqualified strobes leave the byte pointer alone; start while busy ignored.
    mem[0] = 12'h2AB;
    mem[1] = 12'h3CD;
    pulse_start(12'd2);
    push_sample(mem[0]);
    push_sample(mem[1]);
    host_read(1'b0);
    host_ignored(2'd0, 1'b1);
    host_ignored(2'd1, 1'b1);
    host_ignored(2'd2, 1'b1);
    host_ignored(DADDR, 1'b0);
    pulse_start(12'd5);
    chk("busy_start_ignored", bus.busy, 1'b1);
    host_read(1'b0);
    host_read(1'b0);
    host_read(1'b0);
    wait_done();

    // Zero-length start: done pulse, busy never raised.
    @(negedge clk);
    bus.start = 1'b1;
    bus.nSamples = 12'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("zero_done", bus.done, 1'b1);
    busy_seen = bus.busy;
    @(negedge clk);
    chk("zero_done_single", bus.done, 1'b0);
    repeat (3) begin @(negedge clk); if (bus.busy) busy_seen = 1'b1; end
    chk("zero_busy", busy_seen, 1'b0);

    // Strobe in IDLE gets a dummy 8'h00 handshake.
    sb_q.push_back(8'h00);
    host_read(1'b1);
    chk("idle_busy", bus.busy, 1'b0);

    // Reset in the middle of a four-sample read, after the third byte.
    mem[0] = 12'h5A1;
    mem[1] = 12'h6B2;
    mem[2] = 12'h7C3;
    mem[3] = 12'h8D4;
    pulse_start(12'd4);
    for (int i = 0; i < 4; i++) push_sample(mem[i]);
    host_read(1'b0);
    host_read(1'b0);
    host_read(1'b0);
    #3;
    rstN = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb_q.delete();
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    sb_q.push_back(8'h00);
    host_read(1'b0);
    pulse_start(12'd1);
    chk("restart_addr", bus.busBramAddr, 12'd0);
    push_sample(mem[0]);
    host_read(1'b0);
    host_read(1'b0);
    wait_done();
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wac_epp_reader.md
WAC_EPP_READER -- requirements
Module: wac_epp_reader

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flops synchronising dataStb and eppWrite to clk.
REQ-002 Parameter: DATA_ADDR, default 2'd3, addrEpp value selecting the sample read-back register.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  system clock, rising edge.
REQ-005 Port: rstN  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  single-cycle pulse from the capture controller; arms read-back of nSamples samples.
REQ-007 Port: nSamples  input  12  sample count, sampled on start.
REQ-008 Port: dataStb  input  1  EPP data strobe, active-low, asynchronous to clk.
REQ-009 Port: eppWrite  input  1  EPP direction, asynchronous; 1 = host read, 0 = host write.
REQ-010 Port: addrEpp  input  2  EPP register address, stable while dataStb low.
REQ-011 Port: busBramAddr  output  12  BRAM read address.
REQ-012 Port: busBramIn  input  12  BRAM read data, valid 1 cycle after busBramAddr.
REQ-013 Port: eppDataOut  output  8  byte presented to host.
REQ-014 Port: eppWait  output  1  EPP wait, active-high; byte valid while high.
REQ-015 Port: busy  output  1  high from accepted start until done.
REQ-016 Port: done  output  1  single-cycle pulse at end of read-back.

Function
REQ-017 dataStb and eppWrite SHALL pass through SYNC_STAGES flops; all decisions use the synchronised values (stbS, wrS).
REQ-018 A qualified strobe SHALL be a stbS high-to-low transition with wrS=1 and addrEpp==DATA_ADDR; other strobes SHALL be ignored (eppWait stays 0).
REQ-019 FSM states SHALL be IDLE, FETCH, READY, HOLD, RELEASE.
REQ-020 IDLE: on start with nSamples!=0, latch count, busBramAddr<=0, byteSel<=0, busy<=1, go FETCH; on start with nSamples==0, pulse done next cycle, remain IDLE, busy stays 0.
REQ-021 FETCH: one cycle for BRAM latency; latch busBramIn into sample register; go READY.
REQ-022 READY: on qualified strobe drive eppDataOut (byteSel=0: sample[7:0]; byteSel=1: {4'h0,sample[11:8]}) and set eppWait=1 in the same edge; go HOLD.
REQ-023 HOLD: on stbS high, eppWait<=0; go RELEASE.
REQ-024 RELEASE: if byteSel=0 set byteSel=1, go READY; if byteSel=1 and address != count-1, increment busBramAddr, byteSel<=0, go FETCH; if last, busy<=0, done<=1 for one cycle, busBramAddr<=0, go IDLE.
REQ-025 eppWait SHALL rise exactly 1 clk after stbS falls and fall exactly 1 clk after stbS rises.
REQ-026 eppDataOut SHALL remain stable from eppWait rise until the next qualified strobe.
REQ-027 A qualified strobe in IDLE SHALL be handshaken (eppWait per REQ-025) with eppDataOut=8'h00 so the host never hangs; no state change.
REQ-028 A qualified strobe arriving during FETCH SHALL be held pending and serviced on entry to READY.
REQ-029 start while busy SHALL be ignored.
REQ-030 Address arithmetic SHALL be 12-bit; nSamples=12'hFFF reads addresses 0..12'hFFE; no wrap past count-1.

Reset
REQ-031 On rstN low, asynchronously: state=IDLE, busBramAddr=0, eppDataOut=8'h00, eppWait=0, busy=0, done=0, byteSel=0, synchroniser flops=1 (strobe inactive).
REQ-032 Reset mid-transfer SHALL abandon read-back; after release, the first qualified strobe is handled per REQ-027.

Verification
REQ-033 Basic: BRAM[0]=12'h144, BRAM[1]=12'h147, start with nSamples=2, four read strobes (20 ns low, 20 ns high) -> bytes 44,01,47,01; done pulse after 4th strobe release; busy 0.
REQ-034 Timing: single strobe -> eppWait high exactly 1 clk after synchronised fall, low 1 clk after synchronised rise; eppDataOut stable throughout.
REQ-035 Qualification: strobes with addrEpp=0/1/2 or eppWrite=0 -> eppWait stays 0, byte pointer unchanged.
REQ-036 Boundaries: start with nSamples=0 -> done pulse, busy never 1; start while busy -> ignored; strobe in IDLE -> 8'h00 handshake.
REQ-037 Reset: rstN low after 3rd byte of a 4-sample read -> all outputs at REQ-031 values immediately; next start re-reads from address 0.
